// File: rtl/tdm_pkg.sv
// tdm_pkg: shared state encoding and slot indices for the TDM demultiplexer.
package tdm_pkg;
    typedef enum logic {ST_HUNT = 1'b0, ST_LOCK = 1'b1} state_t;
    localparam int NUM_SLOTS = 4;
    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: 2-bit slot index; loads 1 on a sync beat, increments on other beats, flags slot D.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic       i_inc,
    output logic [1:0] o_slot,
    output logic       o_wrap
);
    logic [1:0] r_slot;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_slot <= SLOT_A;
        else if (i_load) r_slot <= SLOT_B;
        else if (i_inc) r_slot <= r_slot + 2'd1;
    end
    assign o_slot = r_slot;
    assign o_wrap = (r_slot == SLOT_D);
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: splits a 4-slot TDM lane into four double-buffered channel outputs with lock tracking.
// Optional TDM_DEMUX_PARITY_EN adds per-beat even parity (din_par) and a bad-frame pulse (par_err).
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] ch_a,
    output logic [WIDTH-1:0] ch_b,
    output logic [WIDTH-1:0] ch_c,
    output logic [WIDTH-1:0] ch_d,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
`ifdef TDM_DEMUX_PARITY_EN
    ,
    input  logic             din_par,
    output logic             par_err
`endif
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sh [NUM_SLOTS-1];
    logic [WIDTH-1:0] r_ch_a, r_ch_b, r_ch_c, r_ch_d;
    logic             r_fv, r_serr, r_pend;
    logic [1:0]       w_slot;
    logic             w_wrap, w_sync, w_lbeat, w_mis, w_done, w_good;

    assign w_sync  = din_valid & frame_sync;
    assign w_lbeat = (r_state == ST_LOCK) & din_valid & ~frame_sync;
    assign w_mis   = (r_state == ST_LOCK) & w_sync & (w_slot != SLOT_A);
    assign w_done  = w_lbeat & w_wrap;

`ifdef TDM_DEMUX_PARITY_EN
    logic r_bad, r_perr, w_perr, w_start;
    assign w_perr  = din_valid & ((^din) != din_par);
    assign w_start = w_sync | (w_lbeat & (w_slot == SLOT_A));
    assign w_good  = w_done & ~(r_bad | w_perr);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bad  <= 1'b0;
            r_perr <= 1'b0;
        end else begin
            r_perr <= w_done & (r_bad | w_perr);
            if (w_start) r_bad <= w_perr;
            else if (w_lbeat) r_bad <= r_bad | w_perr;
        end
    end
    assign par_err = r_perr;
`else
    assign w_good = w_done;
`endif

    tdm_slot_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_sync),
        .i_inc  (w_lbeat),
        .o_slot (w_slot),
        .o_wrap (w_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_HUNT;
        else r_state <= w_next;
    end

    // a second misaligned sync before any good frame drops lock
    always_comb begin
        w_next = r_state;
        if (r_state == ST_HUNT && w_sync) w_next = ST_LOCK;
        if (w_mis && r_pend) w_next = ST_HUNT;
        locked = (r_state == ST_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS - 1; i++) r_sh[i] <= '0;
            r_ch_a <= '0;
            r_ch_b <= '0;
            r_ch_c <= '0;
            r_ch_d <= '0;
            r_fv   <= 1'b0;
            r_serr <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_fv   <= w_good;
            r_serr <= w_mis;
            if (w_mis) r_pend <= ~r_pend;
            else if (w_good) r_pend <= 1'b0;
            if (w_sync) r_sh[0] <= din;
            else if (w_lbeat)
                for (int i = 0; i < NUM_SLOTS - 1; i++)
                    if (w_slot == 2'(i)) r_sh[i] <= din;
            if (w_good) begin
                r_ch_a <= r_sh[0];
                r_ch_b <= r_sh[1];
                r_ch_c <= r_sh[2];
                r_ch_d <= din;
            end
        end
    end

    assign ch_a        = r_ch_a;
    assign ch_b        = r_ch_b;
    assign ch_c        = r_ch_c;
    assign ch_d        = r_ch_d;
    assign frame_valid = r_fv;
    assign sync_err    = r_serr;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed and random stimulus checked against a queue-based frame model.
module tb_tdm_demux4;
    logic       clk = 0;
    logic       rst = 1;
    logic [3:0] din = '0;
    logic       din_valid = 0;
    logic       frame_sync = 0;
    logic [3:0] ch_a, ch_b, ch_c, ch_d;
    logic       frame_valid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
    logic       par_err;
`endif

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .ch_a        (ch_a),
        .ch_b        (ch_b),
        .ch_c        (ch_c),
        .ch_d        (ch_d),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
`ifdef TDM_DEMUX_PARITY_EN
        ,
        .din_par     (^din),
        .par_err     (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  m_q [$];
    bit          m_locked = 0;
    bit          m_pend = 0;
    logic [15:0] m_ch = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_locked = 0;
        m_pend = 0;
        m_ch = '0;
    endtask

    // one cycle: apply inputs, advance the frame model, compare after the edge
    task automatic step(input bit v, input bit s, input logic [3:0] d);
        bit e_fv, e_se;
        e_fv = 0;
        e_se = 0;
        din = d;
        din_valid = v;
        frame_sync = s;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_q = {d};
                    m_locked = 1;
                end
            end else if (s && m_q.size() != 0) begin
                e_se = 1;
                m_q = {d};
                if (m_pend) begin
                    m_locked = 0;
                    m_pend = 0;
                end else m_pend = 1;
            end else begin
                if (s) m_q = {d};
                else m_q.push_back(d);
                if (m_q.size() == 4) begin
                    m_ch = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    e_fv = 1;
                    m_pend = 0;
                    m_q.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        chk("ch", {ch_a, ch_b, ch_c, ch_d}, m_ch);
        chk("frame_valid", frame_valid, e_fv);
        chk("sync_err", sync_err, e_se);
        chk("locked", locked, m_locked);
    endtask

    task automatic check_zero(input string tag);
        chk(tag, {ch_a, ch_b, ch_c, ch_d, frame_valid, locked, sync_err}, '0);
    endtask

    task automatic async_reset();
        din_valid = 0;
        frame_sync = 0;
        rst = 1;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 0;
        step(0, 0, 4'h0);
        // acquire and first frame
        step(1, 1, 4'h1);
        chk("lock_after_sync", locked, 1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        step(1, 0, 4'h4);
        chk("frame1", {ch_a, ch_b, ch_c, ch_d}, 16'h1234);
        step(0, 0, 4'h0);
        // beats before sync are discarded
        async_reset();
        for (int i = 5; i <= 8; i++) step(1, 0, 4'(i));
        chk("hunt_unlocked", locked, 0);
        step(1, 1, 4'h9);
        step(1, 0, 4'hA);
        step(1, 0, 4'hB);
        step(1, 0, 4'hC);
        chk("frame2", {ch_a, ch_b, ch_c, ch_d}, 16'h9ABC);
        // misaligned sync restarts the frame
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 1, 4'h7);
        chk("mis_serr", sync_err, 1);
        step(1, 0, 4'h8);
        step(1, 0, 4'h9);
        step(1, 0, 4'hA);
        chk("frame3", {ch_a, ch_b, ch_c, ch_d}, 16'h789A);
        // gaps between beats
        for (int i = 3; i <= 6; i++) begin
            step(1, i == 3, 4'(i));
            if (i != 6) begin
                step(0, 1, 4'hF);
                step(0, 0, 4'hE);
            end
        end
        chk("frame4", {ch_a, ch_b, ch_c, ch_d}, 16'h3456);
        // two misaligned syncs drop lock
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 1, 4'h3);
        step(1, 0, 4'h4);
        step(1, 1, 4'h5);
        chk("unlock", locked, 0);
        // reset mid-frame
        step(1, 1, 4'hD);
        step(1, 0, 4'hE);
        async_reset();
        step(1, 0, 4'h1);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit v, s;
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 9) < 2);
            step(v, s, 4'($urandom));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
